// File: rtl/m_imem_loader_pkg.sv
// Shared encodings for the serial program loader and its UART receiver.
package m_imem_loader_pkg;

  // Header is a little-endian word count of this many bytes.
  localparam int HDR_BYTES = 2;
  localparam int LEN_W     = 8 * HDR_BYTES;

  // Loader FSM. LEN0 keeps its encoding but is never entered: the low
  // count byte is taken directly in IDLE.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // UART receiver FSM.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/m_imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, falling-edge start detection with
// a mid-bit glitch re-check, LSB-first data sampling at bit centres.
// Output handshake: o_valid is a one-cycle pulse qualifying o_data; there is
// no ready/backpressure, so the consumer must take the byte in that cycle.
// o_ferr is a one-cycle pulse instead of o_valid when the stop bit reads 0.
// o_start pulses once when a start bit survives the mid-bit re-check.
module m_uart_rx
  import m_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic       o_start,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_ferr
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  rx_state_e   state_q, state_d;
  logic [2:0]  sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        start_q, start_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rxd_s, rxd_prev;

  assign rxd_s    = sync_q[1];
  assign rxd_prev = sync_q[2];

  // Synchroniser plus one history flop for edge detection; resets to the idle-high level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], i_rxd};
  end

  // Receiver state and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      start_q <= start_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit timing: the counter restarts at every sample point, so each
  // subsequent sample lands a full bit time after the previous centre.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    start_d = 1'b0;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxd_s && rxd_prev) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            bidx_d  = '0;
            start_d = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          sh_d  = {rxd_s, sh_q[7:1]};
          if (bidx_q == 3'd7) state_d = RX_STOP;
          else                bidx_d  = bidx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rxd_s) begin
            valid_d = 1'b1;
            data_d  = sh_q;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_start = start_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_ferr  = ferr_q;

endmodule

// File: rtl/m_imem_loader.sv
// Serial program loader: turns a UART byte stream (2-byte count N, then N
// little-endian 32-bit words) into single-cycle memory writes, holding the
// processor in reset for the duration of the load.
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_wdata,
  output logic              r_cpu_rst,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_err,
  output logic [LEN_W-1:0]  r_nwords
);

  localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TMO_LIMIT + 1);
  // Largest legal word count: the whole memory, no wrap-around.
  localparam logic [LEN_W:0] DEPTH = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  logic       rx_start, rx_valid, rx_ferr;
  logic [7:0] rx_data;

  m_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk   (w_clk),
    .i_rst   (w_rst),
    .i_rxd   (w_rxd),
    .o_start (rx_start),
    .o_valid (rx_valid),
    .o_data  (rx_data),
    .o_ferr  (rx_ferr)
  );

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        nlo_q, nlo_d;
  logic [LEN_W-1:0]  nwords_q, nwords_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [LEN_W-1:0]  n_full;
  logic              tmo_hit;

  assign n_full  = {rx_data, nlo_q};
  // A byte landing in the expiry cycle keeps the load alive.
  assign tmo_hit = (tmo_q == TW'(TMO_LIMIT - 1)) && !rx_valid;

  // Loader state and output registers.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      idx_q    <= '0;
      nlo_q    <= '0;
      nwords_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      done_q   <= done_d;
      we_q     <= we_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      nlo_q    <= nlo_d;
      nwords_q <= nwords_d;
      tmo_q    <= tmo_d;
    end
  end

  // Header parsing, word assembly, write generation, completion and abort.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    err_d    = err_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    last_d   = last_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    nlo_d    = nlo_q;
    nwords_d = nwords_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (rx_ferr) begin
          err_d  = 1'b1;
          busy_d = 1'b0;
        end else if (rx_valid) begin
          nlo_d   = rx_data;
          busy_d  = 1'b1;
          state_d = S_LEN1;
        end else if (rx_start) begin
          busy_d = 1'b1;
        end
      end
      S_LEN1: begin
        if (rx_ferr || tmo_hit) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (rx_valid) begin
          tmo_d    = '0;
          nwords_d = n_full;
          if ({1'b0, n_full} > DEPTH) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (n_full == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            idx_d   = '0;
            last_d  = 1'b0;
            state_d = S_DATA;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DATA: begin
        if (last_q) begin
          // Final word was written last cycle.
          last_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (rx_ferr || tmo_hit) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (rx_valid) begin
          tmo_d = '0;
          idx_d = idx_q + 2'd1;
          buf_d[{idx_q, 3'b000} +: 8] = rx_data;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = cnt_q;
            wdata_d = {rx_data, buf_q[23:0]};
            cnt_d   = cnt_q + ADDR_W'(1);
            last_d  = (LEN_W'(cnt_q) == nwords_q - LEN_W'(1));
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign r_we      = we_q;
  assign r_addr    = addr_q;
  assign r_wdata   = wdata_q;
  assign r_busy    = busy_q;
  assign r_cpu_rst = busy_q;
  assign r_done    = done_q;
  assign r_err     = err_q;
  assign r_nwords  = nwords_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for the serial program loader with a frame-level model.
module tb_m_imem_loader;

  localparam int CPB   = 4;
  localparam int TBITS = 16;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic          w_rxd;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_cpu_rst, r_busy, r_done, r_err;
  logic [15:0]   r_nwords;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected writes {addr, data} and expected done pulses (word count).
  logic [AW+31:0] exp_q[$];
  logic [15:0]    done_q[$];
  logic           exp_err;
  logic [15:0]    exp_nwords;
  logic           busy_seen;

  // Clock and reset.
  always #5 w_clk = ~w_clk;

  m_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_BITS(TBITS)) dut (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .w_rxd     (w_rxd),
    .r_we      (r_we),
    .r_addr    (r_addr),
    .r_wdata   (r_wdata),
    .r_cpu_rst (r_cpu_rst),
    .r_busy    (r_busy),
    .r_done    (r_done),
    .r_err     (r_err),
    .r_nwords  (r_nwords)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the scoreboard.
  always @(negedge w_clk) begin
    if (!w_rst) begin
      if (r_busy) busy_seen = 1'b1;
      check("cpu_rst_tracks_busy", r_cpu_rst, r_busy);
      if (r_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL write_unexpected: got addr %0h data %0h, expected no write", r_addr, r_wdata);
        end else begin
          logic [AW+31:0] e;
          e = exp_q.pop_front();
          check("write_addr", r_addr, e[AW+31:32]);
          check("write_data", r_wdata, e[31:0]);
          check("write_while_busy", r_busy, 1);
        end
      end
      if (r_done) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_unexpected: got r_done=1, expected 0");
        end else begin
          logic [15:0] n;
          n = done_q.pop_front();
          check("done_nwords", r_nwords, n);
          check("done_busy_low", r_busy, 0);
          check("done_err_clear", r_err, 0);
          check("done_after_writes", exp_q.size(), 0);
        end
      end
    end
  end

  // Driver: one 8N1 character, stop bit value selectable.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    w_rxd = 1'b0;
    repeat (CPB) @(negedge w_clk);
    for (int i = 0; i < 8; i++) begin
      w_rxd = b[i];
      repeat (CPB) @(negedge w_clk);
    end
    w_rxd = stop;
    repeat (CPB) @(negedge w_clk);
    w_rxd = 1'b1;
  endtask

  // Frame model: what a byte sequence must produce, from the frame rules alone.
  // bad = index of the byte whose stop bit is 0 (-1 for none).
  task automatic model_frame(input logic [7:0] b[$], input int bad);
    int good, n, avail, nw;
    good = (bad < 0) ? b.size() : bad;
    if (good < 2) begin
      exp_err = 1'b1;
      return;
    end
    n = {16'd0, b[1], b[0]};
    exp_nwords = n[15:0];
    if (n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    avail = (good - 2) / 4;
    nw = (avail < n) ? avail : n;
    for (int k = 0; k < nw; k++)
      exp_q.push_back({AW'(k), b[2+4*k+3], b[2+4*k+2], b[2+4*k+1], b[2+4*k]});
    if (avail >= n) begin
      done_q.push_back(n[15:0]);
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // Send a modelled frame, optionally probe mid-way through the idle tail, then check end state.
  task automatic drive_frame(input string name, input logic [7:0] b[$], input int bad,
                             input int mid, input int settle);
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], (i == bad) ? 1'b0 : 1'b1);
      if (i == 0 && bad != 0) check({name, "_busy_mid"}, r_busy, 1);
      if (i == bad) break;
    end
    if (mid > 0) begin
      repeat (mid) @(negedge w_clk);
      check({name, "_err_not_early"}, r_err, 0);
      check({name, "_busy_not_early"}, r_busy, 1);
    end
    repeat (settle) @(negedge w_clk);
    check({name, "_err"}, r_err, exp_err);
    check({name, "_busy_end"}, r_busy, 0);
    check({name, "_cpu_rst_end"}, r_cpu_rst, 0);
    check({name, "_nwords"}, r_nwords, exp_nwords);
    check({name, "_writes_pending"}, exp_q.size(), 0);
    check({name, "_done_pending"}, done_q.size(), 0);
  endtask

  task automatic run_frame(input string name, input logic [7:0] b[$], input int bad,
                           input int mid, input int settle);
    model_frame(b, bad);
    drive_frame(name, b, bad, mid, settle);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_we"}, r_we, 0);
    check({name, "_addr"}, r_addr, 0);
    check({name, "_wdata"}, r_wdata, 0);
    check({name, "_cpu_rst"}, r_cpu_rst, 0);
    check({name, "_busy"}, r_busy, 0);
    check({name, "_done"}, r_done, 0);
    check({name, "_err"}, r_err, 0);
    check({name, "_nwords"}, r_nwords, 0);
  endtask

  logic [7:0] fb[$];
  logic [7:0] pb;

  initial begin
    w_rst      = 1'b1;
    w_rxd      = 1'b1;
    exp_err    = 1'b0;
    exp_nwords = 16'd0;
    busy_seen  = 1'b0;
    repeat (3) @(negedge w_clk);
    check_all_zero("reset");
    w_rst = 1'b0;
    repeat (5) @(negedge w_clk);

    // Two-word frame.
    fb = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_frame(fb, -1);
    check("pin_t1_word0", exp_q[0], {12'h000, 32'h12345678});
    check("pin_t1_word1", exp_q[1], {12'h001, 32'hDEADBEEF});
    check("pin_t1_count", exp_nwords, 16'd2);
    drive_frame("t1", fb, -1, 0, 20);

    // Empty image.
    fb = '{8'h00, 8'h00};
    run_frame("t2", fb, -1, 0, 20);

    // Truncated frame: timeout after 64 idle cycles.
    fb = '{8'h01, 8'h00, 8'h11, 8'h22};
    run_frame("t3", fb, -1, 40, 30);
    check("t3_err_literal", r_err, 1);
    fb = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    run_frame("t3b", fb, -1, 0, 20);

    // Oversized header.
    fb = '{8'h01, 8'h10};
    model_frame(fb, -1);
    check("pin_t5_count", exp_nwords, 16'd4097);
    drive_frame("t5", fb, -1, 0, 20);
    check("t5_nwords_literal", r_nwords, 16'd4097);

    // FSM back in IDLE: an empty image completes and clears the error.
    fb = '{8'h00, 8'h00};
    run_frame("t5b", fb, -1, 0, 20);

    // Framing error on the third byte.
    fb = '{8'h01, 8'h00, 8'h55};
    run_frame("t4", fb, 2, 0, 20);

    // Short low glitch on an idle line.
    busy_seen = 1'b0;
    w_rxd = 1'b0;
    repeat (2) @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (30) @(negedge w_clk);
    check("glitch_no_busy", busy_seen, 0);
    check("glitch_err_sticky", r_err, 1);

    // Reset in the middle of byte 3 of word 0.
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    pb = 8'hCC;
    w_rxd = 1'b0;
    repeat (CPB) @(negedge w_clk);
    for (int i = 0; i < 3; i++) begin
      w_rxd = pb[i];
      repeat (CPB) @(negedge w_clk);
    end
    check("t6_busy_before_rst", r_busy, 1);
    check("t6_nwords_before_rst", r_nwords, 16'd1);
    w_rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    w_rxd = 1'b1;
    repeat (3) @(negedge w_clk);
    w_rst = 1'b0;
    exp_err    = 1'b0;
    exp_nwords = 16'd0;
    repeat (5) @(negedge w_clk);
    fb = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    model_frame(fb, -1);
    check("pin_t6_word0", exp_q[0], {12'h000, 32'hDDCCBBAA});
    drive_frame("t6", fb, -1, 0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_imem_loader.md
Name: m_imem_loader

Overview:
- Serial program loader: the writer side of the processor's instruction and data memory.
- Receives a binary image over an 8N1 UART line, assembles 32-bit words, and drives a single-cycle write port into an m_memory-style RAM (12-bit word address, 32-bit data).
- Holds the processor in reset while loading; releases it when the image is complete.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- ADDR_W, 12, memory word-address width; depth = 2**ADDR_W words.
- TIMEOUT_BITS, 64, idle bit-times allowed mid-frame before the load is aborted.

Ports:
- w_clk  in  1  clock, rising edge.
- w_rst  in  1  reset; asynchronous and active-high; clears all state.
- w_rxd  in  1  UART receive line; asynchronous to w_clk; idles high.
- r_we  out  1  memory write strobe; one cycle per word.
- r_addr  out  ADDR_W  memory word address for r_we.
- r_wdata  out  32  memory write data for r_we.
- r_cpu_rst  out  1  processor reset request; high while loading.
- r_busy  out  1  high from the header's first start bit until done or abort.
- r_done  out  1  one-cycle pulse on successful load completion.
- r_err  out  1  sticky error flag.
- r_nwords  out  16  word count of the last accepted header.

Behaviour:
- Reset: every output is 0; FSM returns to IDLE; the receiver returns to idle. Reset mid-load abandons the load without any further r_we; memory already written is left unchanged.
- Receiver (m_uart_rx):
  - Synchronises w_rxd through 2 flops.
  - A falling edge starts bit timing. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads high, the event is a glitch and the receiver returns to idle.
  - 8 data bits are sampled at bit centres, LSB first, then the stop bit.
  - Emits a byte-valid pulse plus the byte in the cycle after the stop sample. A stop bit of 0 raises a framing-error pulse instead.
- Frame format: 2-byte little-endian word count N, followed by N words of 4 bytes each, little-endian (first byte = bits 7:0).
- FSM states: IDLE, LEN0, LEN1, DATA, DONE.
  - IDLE: the first byte-valid is latched as the N low byte. r_busy=1 and r_cpu_rst=1 from the first start-bit detection. Go to LEN1.
  - LEN0: reserved encoding; unreachable.
  - LEN1: the high byte completes N, which is latched into r_nwords.
    - N > 2**ADDR_W: r_err=1, return to IDLE.
    - N == 0: go to DONE.
    - Otherwise: address counter = 0, byte index = 0, go to DATA.
  - DATA: each byte shifts into the word buffer at [8*idx+7:8*idx].
    - On idx==3: r_we=1 for exactly the next cycle, with r_wdata = the assembled word and r_addr = the counter. The counter increments after the write.
    - After the write of word N-1, go to DONE.
  - DONE: one cycle. r_done=1; r_busy and r_cpu_rst drop to 0 in the same cycle; r_err is cleared; return to IDLE.
- Abort conditions, outside IDLE: a framing error, or TIMEOUT_BITS*CLKS_PER_BIT cycles with no byte-valid. On abort: r_err=1, r_busy=0, r_cpu_rst=0, no further writes, FSM returns to IDLE. Words already written stay in memory.
- A framing error in IDLE sets r_err and does not start a load.
- r_err stays set until the next DONE or reset.
- r_addr and r_wdata hold their last values when r_we=0.
- The word count is exact: no address wrap-around. N == 2**ADDR_W fills the whole memory.
- A byte arriving in the same cycle as a timeout expiry is treated as valid; the byte wins.

Decomposition:
- Shared package: state encodings (IDLE..DONE) and the frame-header byte count (2).
- Sub-module: m_uart_rx (synchroniser, bit timer, shift register, byte-valid and framing-error pulses).
- The parent m_imem_loader holds the FSM, word assembler, address counter and timeout counter.

Test Plan (all scenarios use CLKS_PER_BIT=4 and TIMEOUT_BITS=16):
1. Send 02 00 | 78 56 34 12 | EF BE AD DE -> r_we twice: addr 0 data 12345678, then addr 1 data DEADBEEF. Then r_done one cycle, r_nwords=2, r_cpu_rst 1->0, r_err=0.
2. Send 00 00 -> no r_we; r_done pulse after the second byte; r_nwords=0.
3. Send 01 00 11 22, then line idle 70 cycles -> no r_we; r_err=1, r_busy=0 after 64 idle cycles. A subsequent valid 1-word frame clears r_err on its r_done.
4. Send 01 00 with the 3rd byte's stop bit forced 0 -> r_err=1, no write. A 2-cycle low glitch on an idle line -> no byte, no r_busy.
5. Send header 01 10 (N=4097) -> r_err=1, r_nwords=4097, no writes, FSM back in IDLE.
6. Assert w_rst during byte 3 of word 0 -> all outputs 0 at once. A fresh frame 01 00 AA BB CC DD then writes addr 0 data DDCCBBAA.
